// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one sequential Booth multiplier between N_REQ requesters.
// Optional WAIT-state watchdog with o_err output: define BOOTH_MULT_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned DW          = 8,
    parameter int unsigned PW          = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*DW-1:0]   i_mc,
    input  logic [N_REQ*DW-1:0]   i_mp,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_done,
    output logic [PW-1:0]         o_product,
    output logic                  o_busy,
    output logic                  o_mult_start,
    output logic [DW-1:0]         o_mult_mc,
    output logic [DW-1:0]         o_mult_mp,
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
    output logic                  o_err,
`endif
    input  logic                  i_mult_rdy,
    input  logic [PW-1:0]         i_mult_product
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (PW != 2 * DW || N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("booth_mult_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       winner_q;
    logic                seen_low_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    done_q;
    logic [PW-1:0]       product_q;
    logic                busy_q;
    logic                start_q;
    logic [DW-1:0]       mc_q;
    logic [DW-1:0]       mp_q;

`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0]       tmo_q;
    logic                err_q;
    assign o_err = err_q;
`endif

    logic                pick_vld_d;
    logic [IW-1:0]       pick_idx_d;
    logic [N_REQ-1:0]    pick_gnt_d;
    logic [DW-1:0]       pick_mc_d;
    logic [DW-1:0]       pick_mp_d;
    logic [IW-1:0]       ptr_d;

    // Round-robin scan starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin : p_pick
        int unsigned j;
        j          = 0;
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!pick_vld_d && i_req[IW'(j)]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = IW'(j);
            end
        end
        pick_gnt_d = N_REQ'(1) << pick_idx_d;
        pick_mc_d  = i_mc[pick_idx_d*DW +: DW];
        pick_mp_d  = i_mp[pick_idx_d*DW +: DW];
        ptr_d      = (winner_q == IW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
    end

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            winner_q   <= '0;
            seen_low_q <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            product_q  <= '0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            mc_q       <= '0;
            mp_q       <= '0;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        winner_q <= pick_idx_d;
                        gnt_q    <= pick_gnt_d;
                        mc_q     <= pick_mc_d;
                        mp_q     <= pick_mp_d;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    start_q    <= 1'b0;
                    seen_low_q <= 1'b0;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
                    tmo_q      <= '0;
`endif
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // A high rdy only counts once a low has been seen for this operation.
                    if (!i_mult_rdy) begin
                        seen_low_q <= 1'b1;
                    end
                    if (i_mult_rdy && seen_low_q) begin
                        product_q <= i_mult_product;
                        done_q    <= gnt_q;
                        state_q   <= S_DELIVER;
                    end
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
                    else if (tmo_q == CW'(TIMEOUT_CYC - 1)) begin
                        product_q <= '0;
                        done_q    <= gnt_q;
                        err_q     <= 1'b1;
                        state_q   <= S_DELIVER;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_DELIVER: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_gnt        = gnt_q;
    assign o_done       = done_q;
    assign o_product    = product_q;
    assign o_busy       = busy_q;
    assign o_mult_start = start_q;
    assign o_mult_mc    = mc_q;
    assign o_mult_mp    = mp_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed + randomized bench for booth_mult_arbiter with a behavioural multiplier model.
module tb_booth_mult_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*DW-1:0]  mc;
    logic [N*DW-1:0]  mp;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic [PW-1:0]    product;
    logic             busy;
    logic             mult_start;
    logic [DW-1:0]    mult_mc;
    logic [DW-1:0]    mult_mp;
    logic             mult_rdy;
    logic [PW-1:0]    mult_product;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
    logic             err;
`endif

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    booth_mult_arbiter #(.N_REQ(N), .DW(DW), .PW(PW), .TIMEOUT_CYC(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (req),
        .i_mc           (mc),
        .i_mp           (mp),
        .o_gnt          (gnt),
        .o_done         (done),
        .o_product      (product),
        .o_busy         (busy),
        .o_mult_start   (mult_start),
        .o_mult_mc      (mult_mc),
        .o_mult_mp      (mult_mp),
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
        .o_err          (err),
`endif
        .i_mult_rdy     (mult_rdy),
        .i_mult_product (mult_product)
    );

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // Multiplier model: rdy low for 9 cycles after start, optionally overridden.
    logic [3:0]  m_cnt  = '0;
    logic [15:0] m_prod = '0;
    logic        frc_en = 1'b0;
    logic        frc_val = 1'b1;
    always @(posedge clk) begin
        if (mult_start) begin
            m_cnt  <= 4'd9;
            m_prod <= ref_mul(mult_mc, mult_mp);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 4'd1;
        end
    end
    assign mult_rdy     = frc_en ? frc_val : (m_cnt == 0);
    assign mult_product = m_prod;

    // Reference arbitration: first requester at or after ptr_m, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, input logic [N-1:0] exp_done, input logic [15:0] exp_prod);
        int n;
        n = 0;
        while (done == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_prod"}, 32'(product), 32'(exp_prod));
    endtask

    logic [7:0] a0, b0, a1, b1;
    logic [N-1:0] r;
    int w;
    int seen;

    initial begin
        rst = 1'b1; req = '0; mc = '0; mp = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_prod", 32'(product), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(mult_start), 0);
        chk("rst_mc", 32'(mult_mc), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: 5 * -3
        mc = {8'd0, 8'd5}; mp = {8'd0, 8'hFD}; req = 2'b01;
        w = rr_pick(req, ptr_m);
        @(negedge clk);
        chk("t1_start", 32'(mult_start), 1);
        chk("t1_gnt", 32'(gnt), 32'(1 << w));
        chk("t1_busy", 32'(busy), 1);
        chk("t1_mc", 32'(mult_mc), 32'h05);
        chk("t1_mp", 32'(mult_mp), 32'hFD);
        @(negedge clk);
        chk("t1_start_off", 32'(mult_start), 0);
        wait_done("t1", 2'b01, 16'hFFF1);
        req = '0; ptr_m = (w + 1) % N;
        @(negedge clk);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_done_off", 32'(done), 0);
        chk("t1_prod_hold", 32'(product), 32'hFFF1);

        // Reset in IDLE returns the pointer to 0, then both requesters held
        rst = 1'b1; @(negedge clk); rst = 1'b0; ptr_m = 0;
        mc = {8'd7, 8'h80}; mp = {8'd9, 8'h80}; req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            w = rr_pick(req, ptr_m);
            wait_done($sformatf("alt%0d", k), N'(1 << w),
                      ref_mul(mc[w*DW +: DW], mp[w*DW +: DW]));
            ptr_m = (w + 1) % N;
            if (k == 2) req = '0;
            @(negedge clk);
            chk($sformatf("alt%0d_idle", k), 32'(busy), 0);
        end

        // Stale ready level must not complete the operation
        frc_en = 1'b1; frc_val = 1'b1;
        mc = {8'd0, 8'd3}; mp = {8'd0, 8'd11}; req = 2'b01;
        w = rr_pick(req, ptr_m);
        @(negedge clk);
        chk("st_start", 32'(mult_start), 1);
        @(negedge clk);
        chk("st_done_a", 32'(done), 0);
        @(negedge clk);
        chk("st_done_b", 32'(done), 0);
        frc_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("st_low%0d", k), 32'(done), 0);
        end
        frc_val = 1'b1;
        @(negedge clk);
        chk("st_done", 32'(done), 32'(1 << w));
        chk("st_prod", 32'(product), 32'h0021);
        req = '0; frc_en = 1'b0; ptr_m = (w + 1) % N;
        repeat (2) @(negedge clk);

        // Requester drops and operands change while in flight
        mc = {8'd0, 8'd12}; mp = {8'd0, 8'd10}; req = 2'b01;
        w = rr_pick(req, ptr_m);
        repeat (3) @(negedge clk);
        req = '0; mc = '0;
        wait_done("drop", 2'b01, 16'h0078);
        ptr_m = (w + 1) % N;
        repeat (2) @(negedge clk);

        // Reset during WAIT abandons the transaction
        req = 2'b10;
        repeat (3) @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0; ptr_m = 0;
        chk("mr_gnt", 32'(gnt), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_prod", 32'(product), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_mc", 32'(mult_mc), 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        chk("mr_no_done", 32'(seen), 0);
        mc = {8'd4, 8'd6}; mp = {8'd2, 8'hFF}; req = 2'b11;
        w = rr_pick(req, ptr_m);
        @(negedge clk);
        chk("mr_gnt_ptr0", 32'(gnt), 32'(1 << w));
        wait_done("mr", N'(1 << w), 16'hFFFA);
        req = '0; ptr_m = (w + 1) % N;
        repeat (2) @(negedge clk);

        // Randomized transactions against the reference model
        for (int k = 0; k < 10; k++) begin
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            r  = N'($urandom_range(1, 3));
            mc = {a1, a0}; mp = {b1, b0}; req = r;
            w = rr_pick(r, ptr_m);
            @(negedge clk);
            chk($sformatf("rnd%0d_gnt", k), 32'(gnt), 32'(1 << w));
            mc = 16'($urandom); mp = 16'($urandom);
            wait_done($sformatf("rnd%0d", k), N'(1 << w),
                      (w == 0) ? ref_mul(a0, b0) : ref_mul(a1, b1));
            req = '0; ptr_m = (w + 1) % N;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
        // Multiplier never answers: watchdog delivers a zero product with o_err
        frc_en = 1'b1; frc_val = 1'b0;
        mc = {8'd0, 8'd9}; mp = {8'd0, 8'd9}; req = 2'b01;
        w = rr_pick(req, ptr_m);
        @(negedge clk);
        req = '0;
        wait_done("tmo", N'(1 << w), 16'h0000);
        chk("tmo_err", 32'(err), 1);
        ptr_m = (w + 1) % N;
        @(negedge clk);
        chk("tmo_err_off", 32'(err), 0);
        chk("tmo_idle", 32'(busy), 0);
        frc_en = 1'b0;
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
